// File: rtl/stream_demux_1to2_if.sv
// stream_demux_1to2_if
// Bundles the stream signals of the 1:2 demultiplexer.
//   data_i/last_i/sel_i/valid_i/ready_o : input stream (sel_i picks the leg)
//   a_data_o/a_last_o/a_valid_o/a_ready_i : output leg A (sel_i=1)
//   b_data_o/b_last_o/b_valid_o/b_ready_i : output leg B (sel_i=0)
//   busy_o                                : packet in progress
// The master modport is the environment (upstream source plus both
// downstream sinks). The slave modport is the demultiplexer itself.
interface stream_demux_1to2_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_i;
    logic             last_i;
    logic             sel_i;
    logic             valid_i;
    logic             ready_o;

    logic [WIDTH-1:0] a_data_o;
    logic             a_last_o;
    logic             a_valid_o;
    logic             a_ready_i;

    logic [WIDTH-1:0] b_data_o;
    logic             b_last_o;
    logic             b_valid_o;
    logic             b_ready_i;

    logic             busy_o;

    modport master (
        output data_i, last_i, sel_i, valid_i, a_ready_i, b_ready_i,
        input  ready_o, a_data_o, a_last_o, a_valid_o,
               b_data_o, b_last_o, b_valid_o, busy_o
    );

    modport slave (
        input  data_i, last_i, sel_i, valid_i, a_ready_i, b_ready_i,
        output ready_o, a_data_o, a_last_o, a_valid_o,
               b_data_o, b_last_o, b_valid_o, busy_o
    );
endinterface

// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2
// Registered, packet-aware 1:2 stream demultiplexer. The leg is chosen by
// sel_i on the head beat of a packet (1 = leg A, 0 = leg B) and stays locked
// until the beat carrying last_i has been accepted. Each leg has a one-entry
// output register so downstream ready never reaches the other leg.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : stream_demux_1to2_if.slave (input stream, legs A/B, busy_o)
module stream_demux_1to2 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    stream_demux_1to2_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   lock_sel_reg;
    logic   lock_sel_next;

    // Leg index 0 is leg A, leg index 1 is leg B.
    logic [1:0]            slot_valid_reg;
    logic [1:0][WIDTH-1:0] slot_data_reg;
    logic [1:0]            slot_last_reg;
    logic [1:0]            leg_ready;
    logic [1:0]            load;

    logic tgt;       // route select in sel_i polarity
    logic tgt_leg;   // leg index of the current target
    logic in_ready;
    logic accept;
    logic busy;

    assign leg_ready[0] = bus.a_ready_i;
    assign leg_ready[1] = bus.b_ready_i;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            lock_sel_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lock_sel_reg <= lock_sel_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        lock_sel_next = lock_sel_reg;
        case (state_reg)
            IDLE: begin
                // A single-beat packet never leaves IDLE.
                if (accept && !bus.last_i) begin
                    state_next    = LOCK;
                    lock_sel_next = bus.sel_i;
                end
            end
            LOCK: begin
                if (accept && bus.last_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        tgt      = (state_reg == LOCK) ? lock_sel_reg : bus.sel_i;
        tgt_leg  = ~tgt;
        // Only the target leg can stall the input; the other leg drains
        // on its own.
        in_ready = !slot_valid_reg[tgt_leg] || leg_ready[tgt_leg];
        accept   = bus.valid_i && in_ready;
        busy     = (state_reg == LOCK);
    end

    assign bus.ready_o = in_ready;
    assign bus.busy_o  = busy;

    // ------------------------------------------------------------------
    // Per-leg output slots
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_load
            assign load[gi] = accept && (tgt_leg == 1'(gi));
        end
    endgenerate

    // A load takes priority over a drain, so a slot that empties and
    // refills in the same cycle keeps valid high without a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_reg <= '0;
            slot_data_reg  <= '0;
            slot_last_reg  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (load[i]) begin
                    slot_valid_reg[i] <= 1'b1;
                    slot_data_reg[i]  <= bus.data_i;
                    slot_last_reg[i]  <= bus.last_i;
                end else if (slot_valid_reg[i] && leg_ready[i]) begin
                    slot_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.a_valid_o = slot_valid_reg[0];
    assign bus.a_data_o  = slot_data_reg[0];
    assign bus.a_last_o  = slot_last_reg[0];
    assign bus.b_valid_o = slot_valid_reg[1];
    assign bus.b_data_o  = slot_data_reg[1];
    assign bus.b_last_o  = slot_last_reg[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2
// Directed, table-driven bench for stream_demux_1to2. Each table row holds
// the inputs applied for one clock cycle, the expected combinational ready_o
// under those inputs, and the expected registered outputs after the edge.
// The asynchronous mid-packet reset is a hand-written sequence.
module tb_stream_demux_1to2;

    localparam int WIDTH = 8;
    localparam int NVEC  = 20;

    logic clk;
    logic rst_n;

    stream_demux_1to2_if #(.WIDTH(WIDTH)) bus ();

    stream_demux_1to2 #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       s;
        logic       ar;
        logic       br;
        logic       rdy;
        logic       av;
        logic [7:0] ad;
        logic       al;
        logic       bv;
        logic [7:0] bd;
        logic       bl;
        logic       busy;
    } vec_t;

    vec_t vecs [NVEC];
    int   checks;
    int   errors;

    function automatic vec_t mk(
        input logic v, input logic [7:0] d, input logic l, input logic s,
        input logic ar, input logic br, input logic rdy,
        input logic av, input logic [7:0] ad, input logic al,
        input logic bv, input logic [7:0] bd, input logic bl,
        input logic busy
    );
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.s = s; r.ar = ar; r.br = br;
        r.rdy = rdy; r.av = av; r.ad = ad; r.al = al;
        r.bv = bv; r.bd = bd; r.bl = bl; r.busy = busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic s, input logic ar, input logic br);
        bus.valid_i   = v;
        bus.data_i    = d;
        bus.last_i    = l;
        bus.sel_i     = s;
        bus.a_ready_i = ar;
        bus.b_ready_i = br;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //             v  d      l  s  ar br  rdy av ad     al bv bd     bl busy
        // three-beat packet to leg A
        vecs[0]  = mk(1, 8'h11, 0, 1, 1, 1,  1,  1, 8'h11, 0, 0, 8'h00, 0, 1);
        vecs[1]  = mk(1, 8'h22, 0, 1, 1, 1,  1,  1, 8'h22, 0, 0, 8'h00, 0, 1);
        vecs[2]  = mk(1, 8'h33, 1, 1, 1, 1,  1,  1, 8'h33, 1, 0, 8'h00, 0, 0);
        vecs[3]  = mk(0, 8'h00, 0, 0, 1, 1,  1,  0, 8'h00, 0, 0, 8'h00, 0, 0);
        // route lock: head on B, sel_i flips to 1 mid-packet
        vecs[4]  = mk(1, 8'hA0, 0, 0, 1, 1,  1,  0, 8'h00, 0, 1, 8'hA0, 0, 1);
        vecs[5]  = mk(1, 8'hA1, 0, 1, 1, 1,  1,  0, 8'h00, 0, 1, 8'hA1, 0, 1);
        vecs[6]  = mk(1, 8'hA2, 1, 1, 1, 1,  1,  0, 8'h00, 0, 1, 8'hA2, 1, 0);
        vecs[7]  = mk(0, 8'h00, 0, 0, 1, 1,  1,  0, 8'h00, 0, 0, 8'h00, 0, 0);
        // backpressure on B, then drain + overwrite in one cycle
        vecs[8]  = mk(1, 8'h55, 1, 0, 1, 0,  1,  0, 8'h00, 0, 1, 8'h55, 1, 0);
        vecs[9]  = mk(1, 8'h56, 1, 0, 1, 0,  0,  0, 8'h00, 0, 1, 8'h55, 1, 0);
        vecs[10] = mk(1, 8'h56, 1, 0, 1, 1,  1,  0, 8'h00, 0, 1, 8'h56, 1, 0);
        vecs[11] = mk(0, 8'h00, 0, 0, 1, 1,  1,  0, 8'h00, 0, 0, 8'h00, 0, 0);
        // independent legs: A stalled with 0x77, B traffic still flows
        vecs[12] = mk(1, 8'h77, 1, 1, 0, 1,  1,  1, 8'h77, 1, 0, 8'h00, 0, 0);
        vecs[13] = mk(1, 8'hE0, 0, 1, 0, 1,  0,  1, 8'h77, 1, 0, 8'h00, 0, 0);
        vecs[14] = mk(1, 8'h88, 1, 0, 0, 1,  1,  1, 8'h77, 1, 1, 8'h88, 1, 0);
        vecs[15] = mk(0, 8'h00, 0, 0, 1, 1,  1,  0, 8'h00, 0, 0, 8'h00, 0, 0);
        // alternating single-beat packets A, B, A
        vecs[16] = mk(1, 8'h01, 1, 1, 1, 1,  1,  1, 8'h01, 1, 0, 8'h00, 0, 0);
        vecs[17] = mk(1, 8'h02, 1, 0, 1, 1,  1,  0, 8'h00, 0, 1, 8'h02, 1, 0);
        vecs[18] = mk(1, 8'h03, 1, 1, 1, 1,  1,  1, 8'h03, 1, 0, 8'h00, 0, 0);
        vecs[19] = mk(0, 8'h00, 0, 0, 1, 1,  1,  0, 8'h00, 0, 0, 8'h00, 0, 0);

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 1, 1);

        // Reset values
        #12;
        chk("reset a_valid", 16'(bus.a_valid_o), 16'h0);
        chk("reset b_valid", 16'(bus.b_valid_o), 16'h0);
        chk("reset a_data",  16'(bus.a_data_o),  16'h0);
        chk("reset b_data",  16'(bus.b_data_o),  16'h0);
        chk("reset a_last",  16'(bus.a_last_o),  16'h0);
        chk("reset b_last",  16'(bus.b_last_o),  16'h0);
        chk("reset busy",    16'(bus.busy_o),    16'h0);
        chk("reset ready",   16'(bus.ready_o),   16'h1);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].s, vecs[i].ar, vecs[i].br);
            #1;
            chk($sformatf("vec%0d ready", i), 16'(bus.ready_o), 16'(vecs[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d a_valid", i), 16'(bus.a_valid_o), 16'(vecs[i].av));
            chk($sformatf("vec%0d b_valid", i), 16'(bus.b_valid_o), 16'(vecs[i].bv));
            chk($sformatf("vec%0d busy", i),    16'(bus.busy_o),    16'(vecs[i].busy));
            if (vecs[i].av) begin
                chk($sformatf("vec%0d a_data", i), 16'(bus.a_data_o), 16'(vecs[i].ad));
                chk($sformatf("vec%0d a_last", i), 16'(bus.a_last_o), 16'(vecs[i].al));
            end
            if (vecs[i].bv) begin
                chk($sformatf("vec%0d b_data", i), 16'(bus.b_data_o), 16'(vecs[i].bd));
                chk($sformatf("vec%0d b_last", i), 16'(bus.b_last_o), 16'(vecs[i].bl));
            end
            $display("vec %0d: v=%0b d=%02h l=%0b s=%0b ar=%0b br=%0b -> rdy=%0b a=%0b/%02h b=%0b/%02h busy=%0b",
                     i, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].s, vecs[i].ar, vecs[i].br,
                     bus.ready_o, bus.a_valid_o, bus.a_data_o, bus.b_valid_o, bus.b_data_o, bus.busy_o);
        end

        // Reset mid-packet: head 0xC0 to stalled leg A, then async reset.
        @(negedge clk);
        drive(1, 8'hC0, 0, 1, 0, 1);
        #1;
        chk("midrst head ready", 16'(bus.ready_o), 16'h1);
        @(posedge clk);
        #1;
        chk("midrst head a_valid", 16'(bus.a_valid_o), 16'h1);
        chk("midrst head a_data",  16'(bus.a_data_o),  16'hC0);
        chk("midrst head busy",    16'(bus.busy_o),    16'h1);
        drive(0, 8'h00, 0, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst a_valid", 16'(bus.a_valid_o), 16'h0);
        chk("midrst busy",    16'(bus.busy_o),    16'h0);
        chk("midrst b_valid", 16'(bus.b_valid_o), 16'h0);
        #1;
        rst_n = 1'b1;
        $display("midrst: reset pulsed between edges, a_valid=%0b busy=%0b",
                 bus.a_valid_o, bus.busy_o);

        // First beat after reset is a packet head: sel_i=0 routes to B.
        @(negedge clk);
        drive(1, 8'hD0, 1, 0, 1, 1);
        #1;
        chk("post-rst ready", 16'(bus.ready_o), 16'h1);
        @(posedge clk);
        #1;
        chk("post-rst b_valid", 16'(bus.b_valid_o), 16'h1);
        chk("post-rst b_data",  16'(bus.b_data_o),  16'hD0);
        chk("post-rst b_last",  16'(bus.b_last_o),  16'h1);
        chk("post-rst a_valid", 16'(bus.a_valid_o), 16'h0);
        chk("post-rst busy",    16'(bus.busy_o),    16'h0);
        $display("post-rst: D0 -> b_valid=%0b b_data=%02h a_valid=%0b",
                 bus.b_valid_o, bus.b_data_o, bus.a_valid_o);

        @(negedge clk);
        drive(0, 8'h00, 0, 0, 1, 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Registered 1:2 stream demultiplexer: steers one valid/ready input stream to one of two output legs.
- Performs the inverse function of the team's 2:1 mux.
- Legs use the mux's select polarity: sel_i=1 selects leg A, sel_i=0 selects leg B.
- Packet-aware: the route is locked from the first beat to the last_i beat, so packets never split across legs.
- Each leg has a one-entry output register, so downstream timing is isolated from the input.

Parameters:
- WIDTH, 8, data width of input and both output legs.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- data_i  input  WIDTH  input beat data.
- last_i  input  1  marks final beat of a packet.
- sel_i  input  1  route select (1 = leg A, 0 = leg B); sampled only on the first beat of a packet.
- valid_i  input  1  input beat valid.
- ready_o  output  1  input beat accepted when valid_i && ready_o.
- a_data_o  output  WIDTH  leg A data.
- a_last_o  output  1  leg A last.
- a_valid_o  output  1  leg A valid.
- a_ready_i  input  1  leg A downstream ready.
- b_data_o  output  WIDTH  leg B data.
- b_last_o  output  1  leg B last.
- b_valid_o  output  1  leg B valid.
- b_ready_i  input  1  leg B downstream ready.
- busy_o  output  1  1 while a packet is in progress (state LOCK).

Behaviour:
- Reset (rst_ni=0, asynchronous, takes effect immediately):
  - state=IDLE, lock_sel=0.
  - a_valid_o=b_valid_o=0, a_/b_data_o=0, a_/b_last_o=0.
  - busy_o=0; ready_o evaluates to 1 (both slots empty).
- State machine, two states:
  - IDLE: target tgt=sel_i. On an accepted beat with last_i=0, capture lock_sel<=sel_i and go to LOCK. On an accepted beat with last_i=1 (single-beat packet), stay in IDLE.
  - LOCK: tgt=lock_sel; sel_i is ignored. On an accepted beat with last_i=1, go to IDLE. Otherwise stay in LOCK.
- busy_o = (state==LOCK), registered.
- ready_o (combinational): ready_o = !tgt_valid || tgt_ready, where tgt_valid/tgt_ready are the selected leg's slot valid and downstream ready.
  - ready_o never depends on the non-target leg; a stalled non-target leg does not block traffic.
- Accept (valid_i && ready_o): next cycle, the target slot holds data_i/last_i with valid=1.
  - Latency: exactly 1 cycle from acceptance to output valid.
  - Throughput: 1 beat/cycle while downstream ready is held 1.
- Slot drain: leg valid && leg ready with no new accept into that leg -> leg valid<=0. Data and last hold their last value; there is no requirement to clear them.
- Simultaneous drain + accept on the same leg: the slot is overwritten with the new beat and valid stays 1. No bubble, no loss.
- Output rules:
  - Once a leg valid is 1, its data and last stay stable until that leg's ready is 1.
  - A leg valid never deasserts without a handshake.
- The non-target leg's slot keeps draining independently. Both legs may be valid at once, e.g. the tail of a packet on A and the head of the next packet on B.
- Input contract: upstream holds data_i/last_i/sel_i stable while valid_i && !ready_o. The block does not check this contract.
- Reset mid-packet: in-flight slot contents are discarded and state returns to IDLE. The next accepted beat is treated as a packet head.
- No beat is dropped, duplicated or reordered within a leg.

Test Plan:
- Reset, then sel_i=1, three beats 0x11,0x22,0x33(last) with a_ready_i=1:
  - a_valid_o high on 3 consecutive cycles starting 1 cycle after the first accept, data 0x11,0x22,0x33, a_last_o on 0x33.
  - b_valid_o stays 0; busy_o is 1 after the first beat and 0 after the last.
- Route lock: head 0xA0 with sel_i=0, then sel_i toggled to 1 on the 0xA1 and 0xA2(last) beats:
  - all three beats appear on leg B; leg A stays idle.
- Backpressure: b_ready_i=0, send 0x55 (single-beat packet, last) to leg B:
  - b_valid_o=1 holding 0x55; ready_o=0 for further sel_i=0 beats.
  - Raising b_ready_i drains 0x55, and 0x56 is accepted in the same cycle (slot overwrite, no bubble).
- Independent legs: a_ready_i=0 with leg A slot full (0x77), then a sel_i=1 packet head is presented:
  - ready_o=0 while sel_i=1.
  - Switching the presented packet to sel_i=0, beat 0x88 passes to leg B with ready_o=1; 0x77 is still held on A.
- Single-beat packets alternating sel_i 1,0,1 (0x01,0x02,0x03, all last):
  - busy_o stays 0.
  - Beats land on A, B, A respectively, each 1 cycle after acceptance.
- Reset mid-packet: after the 0xC0 head to leg A (busy_o=1), pulse rst_ni=0 asynchronously between clock edges:
  - a_valid_o and busy_o drop immediately.
  - The following sel_i=0 beat 0xD0 routes to leg B.
